// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side handshake, register-file write port and read-hazard signals
// shared between the write arbiter and its neighbours.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               wr_stall;
  logic               wr_ld;
  logic [AW-1:0]      wr_sel;
  logic [DW-1:0]      wr_data;
  logic [AW-1:0]      rd_a_sel;
  logic [AW-1:0]      rd_b_sel;
  logic               rd_a_pend;
  logic               rd_b_pend;

  modport master (
    output req_valid, req_addr, req_data, wr_stall, rd_a_sel, rd_b_sel,
    input  req_ready, wr_ld, wr_sel, wr_data, rd_a_pend, rd_b_pend
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_stall, rd_a_sel, rd_b_sel,
    output req_ready, wr_ld, wr_sel, wr_data, rd_a_pend, rd_b_pend
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port: one grant per
// cycle into a one-deep output stage, plus read-select hazard flags.
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  regfile_wr_arbiter_if.slave   bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic          ld;
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
  } wr_stage_t;

  wr_stage_t       r_stg;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_gnt_idx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [PW:0]     w_idx;
  logic [NREQ-1:0] w_ready;
  logic            w_free;
  logic            w_found;
  logic            w_xfer;

  // Stage can accept when empty or when its current write retires this edge.
  assign w_free = !r_stg.ld || !bus.wr_stall;

  always_comb begin
    w_ready   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) w_idx = w_idx - (PW+1)'(NREQ);
      if (!w_found && bus.req_valid[w_idx[PW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx[PW-1:0];
      end
    end
    if (w_free && !i_rst && w_found) w_ready[w_gnt_idx] = 1'b1;
  end

  assign w_xfer    = |w_ready;
  assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stg <= '0;
      r_ptr <= '0;
    end else if (w_free) begin
      if (w_xfer) begin
        r_stg.ld   <= 1'b1;
        r_stg.sel  <= bus.req_addr[w_gnt_idx*AW +: AW];
        r_stg.data <= bus.req_data[w_gnt_idx*DW +: DW];
        r_ptr      <= w_ptr_nxt;
      end else begin
        r_stg.ld   <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.wr_ld     = r_stg.ld;
  assign bus.wr_sel    = r_stg.sel;
  assign bus.wr_data   = r_stg.data;
  // No bypass path: read side only learns it must wait.
  assign bus.rd_a_pend = r_stg.ld && (r_stg.sel == bus.rd_a_sel);
  assign bus.rd_b_pend = r_stg.ld && (r_stg.sel == bus.rd_b_sel);
endmodule
